memory_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the CPU instruction-fetch bus and the CPU data bus, so a unified memory can back the 5-stage pipeline.
- Sequences each access as issue, wait for memory latency, then respond.
- Returns a one-cycle ready pulse per completed transaction; the requester stalls until it sees that pulse.
- Priority is fixed (data over fetch) or alternating, depending on the optional feature.

---
 rtl/memory_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_memory_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port synchronous RAM between the instruction-fetch
// bus and the data bus. Each access runs IDLE -> ISSUE -> WAIT -> RESPOND and ends
// with a one-cycle ready pulse to the granted requester. All outputs are registered.
//
// Optional feature: define MEMORY_ARBITER_FAIR_EN to alternate grants when both
// requesters are pending; otherwise data has fixed priority over fetch.
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    // Instruction-fetch bus
    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH-1:0] i_fetch_address,
    output logic                  o_fetch_ready,
    output logic [DATA_WIDTH-1:0] o_fetch_data,
    // Data bus
    input  logic                  i_data_req,
    input  logic                  i_data_rw,
    input  logic [ADDR_WIDTH-1:0] i_data_address,
    input  logic [DATA_WIDTH-1:0] i_data_wdata,
    output logic                  o_data_ready,
    output logic [DATA_WIDTH-1:0] o_data_rdata,
    // Memory bus
    output logic                  o_mem_en,
    output logic                  o_mem_rw,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    // Debug
    output logic [1:0]            o_grant
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRespond
    } state_e;

    localparam logic [1:0] GrantNone  = 2'b00;
    localparam logic [1:0] GrantFetch = 2'b01;
    localparam logic [1:0] GrantData  = 2'b10;

    // Counter holds up to MEM_LATENCY-1, and MEM_LATENCY is at most 15.
    localparam int unsigned     CntW    = 4;
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [1:0]              grant_q, grant_d;
    logic                    txn_write_q, txn_write_d;

    logic                    mem_en_q, mem_en_d;
    logic                    mem_rw_q, mem_rw_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic                    fetch_ready_q, fetch_ready_d;
    logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_d;
    logic                    data_ready_q, data_ready_d;
    logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;

    logic                    pick_data;

`ifdef MEMORY_ARBITER_FAIR_EN
    // 1 when the most recent grant went to the data bus.
    logic                    last_data_q, last_data_d;
`endif

    // Arbitration: decide which requester wins if a grant is made this cycle.
    always_comb begin
        pick_data = i_data_req;
`ifdef MEMORY_ARBITER_FAIR_EN
        if (i_data_req && i_fetch_req) begin
            pick_data = !last_data_q;
        end
`endif
    end

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        txn_write_d   = txn_write_q;
        // Memory bus is only driven during ISSUE, so it returns to zero by default.
        mem_en_d      = 1'b0;
        mem_rw_d      = 1'b0;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        fetch_ready_d = fetch_ready_q;
        fetch_data_d  = fetch_data_q;
        data_ready_d  = data_ready_q;
        data_rdata_d  = data_rdata_q;
`ifdef MEMORY_ARBITER_FAIR_EN
        last_data_d   = last_data_q;
`endif

        case (state_q)
            StIdle: begin
                if (i_data_req || i_fetch_req) begin
                    state_d  = StIssue;
                    mem_en_d = 1'b1;
                    if (pick_data) begin
                        grant_d       = GrantData;
                        txn_write_d   = i_data_rw;
                        mem_rw_d      = i_data_rw;
                        mem_address_d = i_data_address;
                        mem_wdata_d   = i_data_rw ? i_data_wdata : '0;
                    end else begin
                        grant_d       = GrantFetch;
                        txn_write_d   = 1'b0;
                        mem_address_d = i_fetch_address;
                    end
`ifdef MEMORY_ARBITER_FAIR_EN
                    last_data_d = pick_data;
`endif
                end
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StRespond;
                    if (grant_q == GrantData) begin
                        data_ready_d = 1'b1;
                        data_rdata_d = txn_write_q ? '0 : i_mem_rdata;
                    end else begin
                        fetch_ready_d = 1'b1;
                        fetch_data_d  = i_mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRespond: begin
                state_d       = StIdle;
                grant_d       = GrantNone;
                fetch_ready_d = 1'b0;
                fetch_data_d  = '0;
                data_ready_d  = 1'b0;
                data_rdata_d  = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; async reset discards any in-flight access.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            grant_q       <= GrantNone;
            txn_write_q   <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            fetch_ready_q <= 1'b0;
            fetch_data_q  <= '0;
            data_ready_q  <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            txn_write_q   <= txn_write_d;
            mem_en_q      <= mem_en_d;
            mem_rw_q      <= mem_rw_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_ready_q <= fetch_ready_d;
            fetch_data_q  <= fetch_data_d;
            data_ready_q  <= data_ready_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

`ifdef MEMORY_ARBITER_FAIR_EN
    // Last-grant register; resets to "data" so the first contested grant goes to fetch.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`endif

    assign o_fetch_ready = fetch_ready_q;
    assign o_fetch_data  = fetch_data_q;
    assign o_data_ready  = data_ready_q;
    assign o_data_rdata  = data_rdata_q;
    assign o_mem_en      = mem_en_q;
    assign o_mem_rw      = mem_rw_q;
    assign o_mem_address = mem_address_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_grant       = grant_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: two instances (MEM_LATENCY=1 and 4), each with a
// memory model whose read data is valid only in the cycle exactly MEM_LATENCY
// cycles after the o_mem_en cycle.
module tb_memory_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;

    logic          fetch_req   [2];
    logic [AW-1:0] fetch_addr  [2];
    logic          fetch_ready [2];
    logic [DW-1:0] fetch_data  [2];
    logic          data_req    [2];
    logic          data_rw     [2];
    logic [AW-1:0] data_addr   [2];
    logic [DW-1:0] data_wdata  [2];
    logic          data_ready  [2];
    logic [DW-1:0] data_rdata  [2];
    logic          mem_en      [2];
    logic          mem_rw      [2];
    logic [AW-1:0] mem_addr    [2];
    logic [DW-1:0] mem_wdata   [2];
    logic [DW-1:0] mem_rdata   [2];
    logic [1:0]    grant       [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {a ^ 16'hC3C3, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : 4;
        int            lat_cnt  = 0;
        logic [AW-1:0] lat_addr = '0;

        memory_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MEM_LATENCY(Lat)
        ) u_dut (
            .i_clk          (clk),
            .i_reset_n      (rst_n),
            .i_fetch_req    (fetch_req[g]),
            .i_fetch_address(fetch_addr[g]),
            .o_fetch_ready  (fetch_ready[g]),
            .o_fetch_data   (fetch_data[g]),
            .i_data_req     (data_req[g]),
            .i_data_rw      (data_rw[g]),
            .i_data_address (data_addr[g]),
            .i_data_wdata   (data_wdata[g]),
            .o_data_ready   (data_ready[g]),
            .o_data_rdata   (data_rdata[g]),
            .o_mem_en       (mem_en[g]),
            .o_mem_rw       (mem_rw[g]),
            .o_mem_address  (mem_addr[g]),
            .o_mem_wdata    (mem_wdata[g]),
            .i_mem_rdata    (mem_rdata[g]),
            .o_grant        (grant[g])
        );

        // Memory latency model: read data valid only Lat cycles after the o_mem_en cycle.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                lat_cnt  <= int'(Lat);
                lat_addr <= mem_addr[g];
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
            end
        end
        assign mem_rdata[g] = (lat_cnt == 1) ? mem_model(lat_addr)
                                             : (32'hBAD0_0000 | 32'(lat_cnt));
    end

    function automatic logic [117:0] outs(input int i);
        return {fetch_ready[i], fetch_data[i], data_ready[i], data_rdata[i],
                mem_en[i], mem_rw[i], mem_addr[i], mem_wdata[i], grant[i]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            fetch_req[i]  = 1'b0;
            fetch_addr[i] = '0;
            data_req[i]   = 1'b0;
            data_rw[i]    = 1'b0;
            data_addr[i]  = '0;
            data_wdata[i] = '0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (outs(i) !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", i, outs(i));
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        n_cmp++;
        if ({mem_en[0], grant[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_no_req: got %b expected 000", {mem_en[0], grant[0]});
        end
    endtask

    task automatic test_fetch_only();
        fetch_addr[0] = 16'h0010;
        fetch_req[0]  = 1'b1;
        step();
        n_cmp++;
        if ({mem_en[0], mem_rw[0], mem_addr[0], grant[0]} !== {1'b1, 1'b0, 16'h0010, 2'b01}) begin
            n_fail++;
            $display("FAIL fetch_issue: got en=%b rw=%b addr=%h grant=%b expected 1 0 0010 01",
                     mem_en[0], mem_rw[0], mem_addr[0], grant[0]);
        end
        step();
        n_cmp++;
        if ({mem_en[0], fetch_ready[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_wait: got en=%b ready=%b expected 0 0", mem_en[0], fetch_ready[0]);
        end
        step();
        n_cmp++;
        if ({fetch_ready[0], fetch_data[0]} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL fetch_ready: got ready=%b data=%h expected 1 deadbeef",
                     fetch_ready[0], fetch_data[0]);
        end
        n_cmp++;
        if (data_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_no_data_ready: got %b expected 0", data_ready[0]);
        end
        fetch_req[0] = 1'b0;
        step();
        n_cmp++;
        if ({fetch_ready[0], fetch_data[0], grant[0]} !== '0) begin
            n_fail++;
            $display("FAIL fetch_clear: got ready=%b data=%h grant=%b expected 0 0 00",
                     fetch_ready[0], fetch_data[0], grant[0]);
        end
    endtask

    task automatic test_data_write();
        data_addr[0]  = 16'h0100;
        data_wdata[0] = 32'h12345678;
        data_rw[0]    = 1'b1;
        data_req[0]   = 1'b1;
        step();
        n_cmp++;
        if ({mem_en[0], mem_rw[0], mem_addr[0], mem_wdata[0], grant[0]}
                !== {1'b1, 1'b1, 16'h0100, 32'h12345678, 2'b10}) begin
            n_fail++;
            $display("FAIL write_issue: got en=%b rw=%b addr=%h wdata=%h grant=%b expected 1 1 0100 12345678 10",
                     mem_en[0], mem_rw[0], mem_addr[0], mem_wdata[0], grant[0]);
        end
        step();
        n_cmp++;
        if ({mem_en[0], mem_rw[0], mem_wdata[0]} !== '0) begin
            n_fail++;
            $display("FAIL write_one_cycle: got en=%b rw=%b wdata=%h expected 0 0 0",
                     mem_en[0], mem_rw[0], mem_wdata[0]);
        end
        step();
        n_cmp++;
        if ({data_ready[0], data_rdata[0], fetch_ready[0]} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL write_ready: got ready=%b rdata=%h fready=%b expected 1 0 0",
                     data_ready[0], data_rdata[0], fetch_ready[0]);
        end
        data_req[0] = 1'b0;
        data_rw[0]  = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_seq [4];
        logic [1:0] who_q   [$];
        logic [1:0] grant_q [$];
        int         t_q     [$];
        int         n_txn;
`ifdef MEMORY_ARBITER_FAIR_EN
        n_txn = 4;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
        n_txn = 2;
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b00; exp_seq[3] = 2'b00;
`endif
        fetch_addr[0] = 16'h0010;
        data_addr[0]  = 16'h0200;
        data_rw[0]    = 1'b0;
        fetch_req[0]  = 1'b1;
        data_req[0]   = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (who_q.size() >= n_txn) break;
            step();
            if (mem_en[0]) grant_q.push_back(grant[0]);
            if (fetch_ready[0]) begin
                who_q.push_back(2'b01);
                t_q.push_back(cyc);
                n_cmp++;
                if (fetch_data[0] !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL sim_fetch_data: got %h expected deadbeef", fetch_data[0]);
                end
`ifndef MEMORY_ARBITER_FAIR_EN
                fetch_req[0] = 1'b0;
`endif
            end
            if (data_ready[0]) begin
                who_q.push_back(2'b10);
                t_q.push_back(cyc);
                n_cmp++;
                if (data_rdata[0] !== mem_model(16'h0200)) begin
                    n_fail++;
                    $display("FAIL sim_data_rdata: got %h expected %h",
                             data_rdata[0], mem_model(16'h0200));
                end
`ifndef MEMORY_ARBITER_FAIR_EN
                data_req[0] = 1'b0;
`endif
            end
        end
        fetch_req[0] = 1'b0;
        data_req[0]  = 1'b0;
        step();
        n_cmp++;
        if (who_q.size() != n_txn || grant_q.size() != n_txn) begin
            n_fail++;
            $display("FAIL sim_count: got readies=%0d issues=%0d expected %0d",
                     who_q.size(), grant_q.size(), n_txn);
        end
        n_cmp++;
        if (t_q.size() == 0 || t_q[0] != 2) begin
            n_fail++;
            $display("FAIL sim_first_ready: got cycle %0d expected 2",
                     (t_q.size() == 0) ? -1 : t_q[0]);
        end
        for (int k = 0; k < n_txn && k < who_q.size() && k < grant_q.size(); k++) begin
            n_cmp++;
            if (who_q[k] !== exp_seq[k] || grant_q[k] !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL sim_order[%0d]: got ready=%b grant=%b expected %b",
                         k, who_q[k], grant_q[k], exp_seq[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (t_q[k] - t_q[k-1] != 4) begin
                    n_fail++;
                    $display("FAIL sim_spacing[%0d]: got %0d expected 4", k, t_q[k] - t_q[k-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t_q [$];
        int en_cnt = 0;
        fetch_addr[0] = 16'h0020;
        fetch_req[0]  = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (t_q.size() >= 3) break;
            step();
            if (mem_en[0]) en_cnt++;
            if (fetch_ready[0]) begin
                t_q.push_back(cyc);
                n_cmp++;
                if (fetch_data[0] !== mem_model(16'h0020)) begin
                    n_fail++;
                    $display("FAIL b2b_data: got %h expected %h", fetch_data[0], mem_model(16'h0020));
                end
                if (t_q.size() == 3) fetch_req[0] = 1'b0;
            end
        end
        step();
        n_cmp++;
        if (t_q.size() != 3 || t_q[0] != 2 || t_q[1] != 6 || t_q[2] != 10) begin
            n_fail++;
            $display("FAIL b2b_timing: got %0d readies %p expected cycles 2 6 10", t_q.size(), t_q);
        end
        n_cmp++;
        if (en_cnt != 3) begin
            n_fail++;
            $display("FAIL b2b_mem_en_count: got %0d expected 3", en_cnt);
        end
    endtask

    task automatic test_latency4();
        logic early  = 1'b0;
        int   en_cnt = 0;
        fetch_addr[1] = 16'h0044;
        fetch_req[1]  = 1'b1;
        step();
        n_cmp++;
        if ({mem_en[1], grant[1], mem_addr[1]} !== {1'b1, 2'b01, 16'h0044}) begin
            n_fail++;
            $display("FAIL lat4_issue: got en=%b grant=%b addr=%h expected 1 01 0044",
                     mem_en[1], grant[1], mem_addr[1]);
        end
        for (int k = 2; k <= 5; k++) begin
            step();
            if (fetch_ready[1]) early = 1'b1;
            if (mem_en[1]) en_cnt++;
        end
        n_cmp++;
        if (early !== 1'b0 || en_cnt != 0) begin
            n_fail++;
            $display("FAIL lat4_wait: got early=%b extra_en=%0d expected 0 0", early, en_cnt);
        end
        step();
        n_cmp++;
        if ({fetch_ready[1], fetch_data[1]} !== {1'b1, mem_model(16'h0044)}) begin
            n_fail++;
            $display("FAIL lat4_ready: got ready=%b data=%h expected 1 %h",
                     fetch_ready[1], fetch_data[1], mem_model(16'h0044));
        end
        fetch_req[1] = 1'b0;
        step();
        n_cmp++;
        if (fetch_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat4_pulse: got %b expected 0", fetch_ready[1]);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic spurious = 1'b0;
        int   t_ready  = -1;
        fetch_addr[1] = 16'h0050;
        fetch_req[1]  = 1'b1;
        step();
        step();
        step();
        n_cmp++;
        if (grant[1] !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_pre_grant: got %b expected 01", grant[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs(1) !== '0) begin
            n_fail++;
            $display("FAIL rst_async_outputs: got %h expected 0", outs(1));
        end
        fetch_req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (fetch_ready[1] || data_ready[1] || mem_en[1]) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_ready: got activity=%b expected 0", spurious);
        end
        fetch_addr[1] = 16'h0060;
        fetch_req[1]  = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (fetch_ready[1]) begin
                t_ready = cyc;
                n_cmp++;
                if (fetch_data[1] !== mem_model(16'h0060)) begin
                    n_fail++;
                    $display("FAIL rst_new_data: got %h expected %h",
                             fetch_data[1], mem_model(16'h0060));
                end
                fetch_req[1] = 1'b0;
                break;
            end
        end
        fetch_req[1] = 1'b0;
        n_cmp++;
        if (t_ready != 5) begin
            n_fail++;
            $display("FAIL rst_new_fetch_time: got cycle %0d expected 5", t_ready);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_data_write();
        test_simultaneous();
        test_back_to_back();
        test_latency4();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
